// File: rtl/mips_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | mips_ctrl_pkg : shared state encoding and default widths           |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        S_PCRST = 3'd0,
        S_HALT  = 3'd1,
        S_RUN   = 3'd2,
        S_STEP  = 3'd3,
        S_DONE  = 3'd4
    } exec_state_t;

    localparam int PC_W_DEF         = 8;
    localparam int DIV_W_DEF        = 26;
    localparam int DEBOUNCE_CYC_DEF = 16;
    localparam int PC_RST_CYC_DEF   = 4;
    localparam int CNT_W_DEF        = 16;

endpackage
`default_nettype wire

// File: rtl/mips_exec_ctrl_key_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | key_debounce : synchronizer, stability counter, press pulse         |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module key_debounce
    import mips_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] run_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            stable  <= 1'b1;
            run_cnt <= '0;
            press   <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= 1'b0;
            // run_cnt counts consecutive samples that disagree with the stable level
            if (sync2 == stable) begin
                run_cnt <= '0;
            end else if (run_cnt == CW'(DEBOUNCE_CYC - 1)) begin
                stable  <= sync2;
                run_cnt <= '0;
                press   <= stable;
            end else begin
                run_cnt <= run_cnt + CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mips_exec_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | mips_exec_ctrl : run/step/breakpoint sequencer issuing cpu_en       |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module mips_exec_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int PC_W         = PC_W_DEF,
    parameter int DIV_W        = DIV_W_DEF,
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int PC_RST_CYC   = PC_RST_CYC_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic             CLOCK_50,
    input  logic             rst_n,
    input  logic             run_sw,
    input  logic [DIV_W-1:0] div_max,
    input  logic             step_key_n,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  pc,
    input  logic             halt_instr,
    output logic             cpu_en,
    output logic             pc_rst,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_cnt,
    output logic             halted
);

    localparam int RST_CW = (PC_RST_CYC > 1) ? $clog2(PC_RST_CYC) : 1;

    exec_state_t       cur_state;
    logic [DIV_W-1:0]  div_cnt;
    logic [RST_CW-1:0] rst_cnt;
    logic              bp_skip;
    logic              run_hold;
    logic              press;
    logic              bp_hit;
    logic              div_tc;

    key_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_key (
        .clk   (CLOCK_50),
        .rst_n (rst_n),
        .key_n (step_key_n),
        .press (press)
    );

    assign bp_hit = bp_en && (pc == bp_addr) && !bp_skip;
    assign div_tc = (div_cnt == div_max);
    assign state  = cur_state;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            instr_cnt <= '0;
        end else if (cpu_en && (instr_cnt != {CNT_W{1'b1}})) begin
            instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_PCRST;
            pc_rst    <= 1'b1;
            cpu_en    <= 1'b0;
            halted    <= 1'b0;
            div_cnt   <= '0;
            rst_cnt   <= '0;
            bp_skip   <= 1'b0;
            run_hold  <= 1'b0;
        end else begin
            cpu_en <= 1'b0;
            // A breakpoint stop with run_sw still high must not resume by itself;
            // the switch has to be seen low once before RUN is accepted again.
            if (!run_sw) begin
                run_hold <= 1'b0;
            end

            case (cur_state)
                S_PCRST: begin
                    if (rst_cnt == RST_CW'(PC_RST_CYC - 1)) begin
                        pc_rst    <= 1'b0;
                        div_cnt   <= '0;
                        cur_state <= run_sw ? S_RUN : S_HALT;
                    end else begin
                        rst_cnt <= rst_cnt + RST_CW'(1);
                    end
                end

                S_RUN: begin
                    if (div_tc) begin
                        div_cnt <= '0;
                        if (halt_instr) begin
                            cur_state <= S_DONE;
                            halted    <= 1'b1;
                        end else if (bp_hit) begin
                            cur_state <= S_HALT;
                            run_hold  <= run_sw;
                        end else begin
                            cpu_en  <= 1'b1;
                            bp_skip <= 1'b0;
                            if (!run_sw) begin
                                cur_state <= S_HALT;
                            end
                        end
                    end else if (!run_sw) begin
                        div_cnt   <= '0;
                        cur_state <= S_HALT;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                S_HALT: begin
                    if (run_sw && !run_hold) begin
                        div_cnt   <= '0;
                        bp_skip   <= 1'b1;
                        cur_state <= S_RUN;
                    end else if (press) begin
                        cur_state <= S_STEP;
                    end
                end

                S_STEP: begin
                    if (halt_instr) begin
                        cur_state <= S_DONE;
                        halted    <= 1'b1;
                    end else begin
                        cpu_en    <= 1'b1;
                        bp_skip   <= 1'b0;
                        cur_state <= S_HALT;
                    end
                end

                S_DONE: begin
                    halted <= 1'b1;
                end

                default: begin
                    cur_state <= S_HALT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_exec_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mips_exec_ctrl : reference-model bench for the exec sequencer    |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_mips_exec_ctrl;
    import mips_ctrl_pkg::*;

    localparam int PC_W  = 8;
    localparam int DIV_W = 26;
    localparam int DEB   = 16;
    localparam int PRC   = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             run_sw = 1'b1;
    logic [DIV_W-1:0] div_max = 26'd3;
    logic             step_key_n = 1'b1;
    logic             bp_en = 1'b0;
    logic [PC_W-1:0]  bp_addr = '0;
    logic [PC_W-1:0]  pc = '0;
    logic             halt_instr = 1'b0;
    logic             cpu_en;
    logic             pc_rst;
    logic [2:0]       state;
    logic [CNT_W-1:0] instr_cnt;
    logic             halted;

    int n_total = 0;
    int n_pass  = 0;

    initial forever #5 clk = ~clk;

    mips_exec_ctrl #(
        .PC_W(PC_W), .DIV_W(DIV_W), .DEBOUNCE_CYC(DEB), .PC_RST_CYC(PRC), .CNT_W(CNT_W)
    ) dut (
        .CLOCK_50(clk), .rst_n(rst_n), .run_sw(run_sw), .div_max(div_max),
        .step_key_n(step_key_n), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
        .halt_instr(halt_instr), .cpu_en(cpu_en), .pc_rst(pc_rst), .state(state),
        .instr_cnt(instr_cnt), .halted(halted)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", name, act, exp);
    endtask

    // Datapath stand-in: pc shows the address of the next instruction, including one in flight.
    logic [PC_W-1:0] pc_reg = '0;
    logic            halt_on = 1'b0;
    logic [PC_W-1:0] halt_pc = '0;
    logic            en_s = 1'b0;
    logic            rst_s = 1'b0;
    int              en_seen = 0;

    initial forever begin
        @(negedge clk);
        en_s  = cpu_en;
        rst_s = pc_rst;
        if (cpu_en) en_seen++;
        @(posedge clk);
        if (rst_s) pc_reg = '0;
        else if (en_s) pc_reg = pc_reg + 1'b1;
        #1;
        pc         = pc_reg + {{(PC_W-1){1'b0}}, cpu_en};
        halt_instr = halt_on && (pc == halt_pc);
    end

    // Behavioural reference model
    exec_state_t m_st;
    bit          m_en;
    int          m_cnt;
    int          m_rst_left;
    int          m_elapsed;
    bit          m_skip;
    bit          m_hold;
    bit          k_d1, k_d2, k_stable, m_press;
    bit          samp_q[$];

    task automatic model_reset();
        m_st = S_PCRST; m_en = 0; m_cnt = 0; m_rst_left = PRC; m_elapsed = 0;
        m_skip = 0; m_hold = 0; k_d1 = 1; k_d2 = 1; k_stable = 1; m_press = 0;
        samp_q.delete();
    endtask

    task automatic model_step();
        bit press_now = m_press;
        bit en_now    = m_en;
        bit s         = k_d2;
        bit all_diff;
        k_d2 = k_d1;
        k_d1 = step_key_n;
        samp_q.push_back(s);
        if (samp_q.size() > DEB) void'(samp_q.pop_front());
        all_diff = (samp_q.size() == DEB);
        foreach (samp_q[i]) if (samp_q[i] == k_stable) all_diff = 0;
        m_press = 0;
        if (all_diff) begin
            m_press  = k_stable;
            k_stable = !k_stable;
        end

        if (en_now && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        m_en = 0;
        if (!run_sw) m_hold = 0;
        case (m_st)
            S_PCRST: begin
                m_rst_left--;
                if (m_rst_left == 0) begin
                    m_st = run_sw ? S_RUN : S_HALT;
                    m_elapsed = 0;
                end
            end
            S_RUN: begin
                if (m_elapsed == int'(div_max)) begin
                    m_elapsed = 0;
                    if (halt_instr) m_st = S_DONE;
                    else if (bp_en && pc == bp_addr && !m_skip) begin
                        m_st = S_HALT;
                        m_hold = run_sw;
                    end else begin
                        m_en = 1; m_skip = 0;
                        if (!run_sw) m_st = S_HALT;
                    end
                end else if (!run_sw) begin
                    m_elapsed = 0;
                    m_st = S_HALT;
                end else m_elapsed++;
            end
            S_HALT: begin
                if (run_sw && !m_hold) begin
                    m_st = S_RUN; m_elapsed = 0; m_skip = 1;
                end else if (press_now) m_st = S_STEP;
            end
            S_STEP: begin
                if (halt_instr) m_st = S_DONE;
                else begin
                    m_en = 1; m_skip = 0; m_st = S_HALT;
                end
            end
            default: ;
        endcase
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) model_reset();
            check("cpu_en",    cpu_en,    m_en);
            check("pc_rst",    pc_rst,    m_st == S_PCRST);
            check("state",     state,     m_st);
            check("halted",    halted,    m_st == S_DONE);
            check("instr_cnt", instr_cnt, m_cnt);
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic count_prst(input string name);
        int n = 0;
        repeat (12) begin
            @(negedge clk);
            if (pc_rst) n++;
        end
        check(name, n, PRC);
    endtask

    int prst_n, first_en, second_en, en0, found, key_left;

    initial begin
        // 1: start-up pc_rst and free-run rate
        #28 rst_n = 1'b1;
        prst_n = 0; first_en = 0; second_en = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (pc_rst) prst_n++;
            if (cpu_en && first_en == 0) first_en = i;
            else if (cpu_en && first_en != 0 && second_en == 0) second_en = i;
        end
        check("t1_pc_rst_cycles", prst_n, 4);
        check("t1_first_en", first_en, 9);
        check("t1_en_period", second_en - first_en, 4);

        // 2: breakpoint stop and resume
        tick(1);
        run_sw = 1; div_max = 0; bp_en = 1; bp_addr = 8'h05;
        do_reset();
        tick(30);
        check("t2_state_halt", state, S_HALT);
        check("t2_instr_cnt", instr_cnt, 5);
        check("t2_pc", pc, 5);
        run_sw = 0;
        tick(3);
        check("t2_still_halt", state, S_HALT);
        run_sw = 1;
        tick(8);
        check("t2_resumed_state", state, S_RUN);
        check("t2_passed_bp", pc > 8'h05, 1);

        // 3: bouncy step key gives one instruction
        run_sw = 0; bp_en = 0;
        do_reset();
        tick(10);
        en0 = en_seen;
        for (int i = 0; i < 5; i++) begin step_key_n = (i % 2 == 1); tick(1); end
        step_key_n = 0; tick(40);
        for (int i = 0; i < 5; i++) begin step_key_n = (i % 2 == 0); tick(1); end
        step_key_n = 1; tick(40);
        check("t3_one_pulse", en_seen - en0, 1);
        check("t3_instr_cnt", instr_cnt, 1);
        check("t3_state", state, S_HALT);

        // 4: halt instruction
        halt_on = 1; halt_pc = 8'd3; run_sw = 1; div_max = 1;
        do_reset();
        tick(30);
        check("t4_state_done", state, S_DONE);
        check("t4_halted", halted, 1);
        check("t4_instr_cnt", instr_cnt, 3);
        en0 = en_seen;
        run_sw = 0; tick(5); run_sw = 1; tick(5);
        step_key_n = 0; tick(30); step_key_n = 1; tick(30);
        check("t4_no_more_en", en_seen - en0, 0);
        check("t4_stays_done", state, S_DONE);
        halt_on = 0;

        // 5: reset during a pulse
        run_sw = 1; div_max = 7;
        do_reset();
        tick(20);
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            if (cpu_en) found = 1;
            else tick(1);
        end
        check("t5_pulse_seen", found, 1);
        #1 rst_n = 1'b0;
        #1;
        check("t5_en_dropped", cpu_en, 0);
        check("t5_pc_rst_on", pc_rst, 1);
        check("t5_state_pcrst", state, S_PCRST);
        @(posedge clk);
        #3 rst_n = 1'b1;
        count_prst("t5_pc_rst_cycles");

        // 6: retired counter saturation
        tick(1);
        run_sw = 1; div_max = 2;
        do_reset();
        tick(80);
        check("t6_saturated", instr_cnt, 15);
        check("t6_running", state, S_RUN);

        // Randomised segments against the model
        for (int seg = 0; seg < 8; seg++) begin
            div_max = 26'($urandom_range(0, 4));
            bp_en   = ($urandom_range(0, 1) == 1);
            bp_addr = 8'($urandom_range(0, 20));
            halt_on = ($urandom_range(0, 3) == 0);
            halt_pc = 8'($urandom_range(2, 30));
            run_sw  = ($urandom_range(0, 1) == 1);
            step_key_n = 1;
            key_left = 0;
            do_reset();
            tick(1);
            repeat (160) begin
                if ($urandom_range(0, 19) == 0) run_sw = !run_sw;
                if (key_left == 0) begin
                    step_key_n = !step_key_n;
                    key_left = $urandom_range(1, 35);
                end else key_left--;
                tick(1);
            end
        end
        halt_on = 0;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
